// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - parametrised shift/funnel/rotate unit with iterative multi-bit engine
module alu_shift_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SW-1:0]    shamt,
  output logic [WIDTH-1:0] result,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_ASHR = 3'b010;
  localparam logic [2:0] OP_FSHR = 3'b011;
  localparam logic [2:0] OP_FSHL = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;
  localparam logic [2:0] OP_ROTL = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // STEP may equal WIDTH, which needs one bit more than the shift amount.
  localparam logic [SW:0] STEP_X = (SW+1)'(STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_n;
  logic [SW-1:0]        count, count_n;
  logic [2*WIDTH-1:0]   funnel, funnel_n, shifted;
  logic                 dir_left, dir_left_n;
  logic [WIDTH-1:0]     result_n;
  logic                 valid_n;
  logic [SW:0]          count_x, k;
  logic                 accept;

  assign ready_o = (state == IDLE) && (!valid_o || ready_i);
  assign busy_o  = (state == SHIFT);
  assign accept  = valid_i && ready_o;

  // Next-state, datapath and output-register logic for both states.
  always_comb begin
    state_n    = state;
    count_n    = count;
    funnel_n   = funnel;
    dir_left_n = dir_left;
    result_n   = result;
    valid_n    = valid_o && !ready_i;
    count_x    = {1'b0, count};
    k          = (count_x > STEP_X) ? STEP_X : count_x;
    shifted    = dir_left ? (funnel << k) : (funnel >> k);
    case (state)
      IDLE: begin
        if (accept) begin
          case (funct)
            OP_SHL:  begin result_n = a << shamt;  valid_n = 1'b1; end
            OP_SHR:  begin result_n = a >> shamt;  valid_n = 1'b1; end
            OP_ASHR: begin result_n = $unsigned($signed(a) >>> shamt); valid_n = 1'b1; end
            OP_PASS: begin result_n = a;           valid_n = 1'b1; end
            default: begin
              if (shamt == '0) begin
                // Zero-distance funnel right selects the low half; all others return a.
                result_n = (funct == OP_FSHR) ? b : a;
                valid_n  = 1'b1;
              end else begin
                funnel_n   = (funct == OP_FSHR || funct == OP_FSHL) ? {a, b} : {a, a};
                count_n    = shamt;
                dir_left_n = (funct == OP_FSHL || funct == OP_ROTL);
                state_n    = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        funnel_n = shifted;
        count_n  = count - k[SW-1:0];
        if (count_x <= STEP_X) begin
          result_n = dir_left ? shifted[2*WIDTH-1:WIDTH] : shifted[WIDTH-1:0];
          valid_n  = 1'b1;
          count_n  = '0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      funnel   <= '0;
      dir_left <= 1'b0;
      result   <= '0;
      valid_o  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      funnel   <= funnel_n;
      dir_left <= dir_left_n;
      result   <= result_n;
      valid_o  <= valid_n;
    end
  end

endmodule

// File: tb/tb_alu_shift_iter.sv
// tb/tb_alu_shift_iter.sv - scoreboard bench for alu_shift_iter with directed vectors
module tb_alu_shift_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;

  alu_shift_iter #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .funct(funct), .a(a), .b(b), .shamt(shamt), .result(result),
    .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   seen = 0;
  int   first_cyc = 0;
  int   valid_seen_after_abort = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_o && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h want none (cycle %0d)", result, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("latency_cycle", first_cyc, e.cyc);
        end
        seen = 0;
      end
    end
  end

  // Drives one request and waits for acceptance; returns the acceptance cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] s, input logic [31:0] exp, input int lat,
                       input bit chk, output int k);
    int waited;
    exp_t e;
    funct = f; a = aa; b = bb; shamt = s; valid_i = 1'b1;
    waited = 0;
    k = -1;
    while (k < 0 && waited < 50) begin
      @(negedge clk);
      if (ready_o) k = cyc;
      else waited++;
    end
    if (k < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no acceptance want acceptance within 50 cycles");
    end else if (chk) begin
      e.res = exp;
      e.cyc = k + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k, k2, w;
    reset = 1'b1; valid_i = 1'b0; funct = '0; a = '0; b = '0; shamt = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_valid_o", {31'b0, valid_o}, 32'd0);
    check("reset_busy_o", {31'b0, busy_o}, 32'd0);
    check("reset_ready_o", {31'b0, ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Simple shifts
    issue(3'b000, 32'h000000F1, 32'h0, 5'd4,  32'h00000F10, 1, 1, k);
    issue(3'b010, 32'h80000000, 32'h0, 5'd31, 32'hFFFFFFFF, 1, 1, k);
    issue(3'b001, 32'h80000000, 32'h0, 5'd31, 32'h00000001, 1, 1, k);
    drain();

    // Funnel ops with busy window check
    issue(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd8, 32'h789ABCDE, 3, 1, k);
    @(negedge clk); check("fshr_busy_k1", {31'b0, busy_o}, 32'd1);
    @(negedge clk); check("fshr_busy_k2", {31'b0, busy_o}, 32'd1);
    @(negedge clk); check("fshr_busy_k3", {31'b0, busy_o}, 32'd0);
    drain();
    issue(3'b100, 32'h12345678, 32'h9ABCDEF0, 5'd8,  32'h3456789A, 3, 1, k);
    issue(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h9ABCDEF0, 1, 1, k);
    issue(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd4,  32'h89ABCDEF, 2, 1, k);
    issue(3'b100, 32'h12345678, 32'h9ABCDEF0, 5'd31, 32'h4D5E6F78, 9, 1, k);
    drain();

    // Rotates
    issue(3'b110, 32'h80000001, 32'hFFFFFFFF, 5'd5,  32'h00000030, 3, 1, k);
    issue(3'b101, 32'h80000001, 32'hFFFFFFFF, 5'd31, 32'h00000003, 9, 1, k);
    issue(3'b101, 32'hCAFEF00D, 32'h0, 5'd0, 32'hCAFEF00D, 1, 1, k);
    drain();

    // Backpressure: stalled result, held request must wait
    ready_i = 1'b0;
    issue(3'b000, 32'h00000001, 32'h0, 5'd31, 32'h80000000, 1, 1, k);
    funct = 3'b111; a = 32'h13579BDF; b = 32'h0; shamt = 5'd0; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid_o", {31'b0, valid_o}, 32'd1);
      check("stall_result", result, 32'h80000000);
      check("stall_ready_o", {31'b0, ready_o}, 32'd0);
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(negedge clk);
    check("release_ready_o", {31'b0, ready_o}, 32'd1);
    begin
      exp_t e;
      e.res = 32'h13579BDF;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
    drain();

    // Back-to-back simple ops with constant ready_o
    issue(3'b000, 32'h000000FF, 32'h0, 5'd8,  32'h0000FF00, 1, 1, k);
    issue(3'b001, 32'hF0000000, 32'h0, 5'd28, 32'h0000000F, 1, 1, k2);
    check("b2b_accept_gap1", 32'(k2 - k), 32'd1);
    issue(3'b111, 32'hDEADBEEF, 32'h0, 5'd3,  32'hDEADBEEF, 1, 1, k);
    check("b2b_accept_gap2", 32'(k - k2), 32'd1);
    drain();

    // Reset in the middle of SHIFT
    issue(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd31, 32'h0, 9, 0, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_busy_o", {31'b0, busy_o}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_valid_o", {31'b0, valid_o}, 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_busy_o", {31'b0, busy_o}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("abort_ready_o", {31'b0, ready_o}, 32'd1);
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o) w++;
    end
    check("abort_no_result", 32'(w), 32'd0);
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
